riscv_lsu: RTL

//  Load/store controller between core datapath and data-memory port. Takes mem_req/mem_we/mem_size from

---
 rtl/riscv_lsu.sv | 114 +++++++++++
 1 files changed

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store sequencer between the core and a req/ack data-memory port,
// with lane steering, load extension, fault detection and a bus timeout.
module riscv_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        fault_o,
    output logic [1:0]  fault_code_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ack_i
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [2:0]  size_q;
    logic [1:0]  lane_q;
    logic [31:0] timer;
    logic        illegal;
    logic        misaligned;
    logic        timeout;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;

    assign core_stall_o = core_req_i & (state != DONE);

    always_comb begin
        illegal    = (core_size_i == 3'd3) || (core_size_i[2:1] == 2'b11) || (core_we_i && core_size_i[2]);
        misaligned = (core_size_i[1:0] == 2'd1 && core_addr_i[0]) ||
                     (core_size_i[1:0] == 2'd2 && core_addr_i[1:0] != 2'b00);
        be = !core_we_i ? 4'b1111 :
             core_size_i[1:0] == 2'd0 ? 4'b0001 << core_addr_i[1:0] :
             core_size_i[1:0] == 2'd1 ? (core_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd = !core_we_i ? 32'd0 :
             core_size_i[1:0] == 2'd0 ? {4{core_wd_i[7:0]}} :
             core_size_i[1:0] == 2'd1 ? {2{core_wd_i[15:0]}} : core_wd_i;
        byte_lane = mem_rd_i[{lane_q, 3'b000} +: 8];
        half_lane = mem_rd_i[{lane_q[1], 4'b0000} +: 16];
        // size bit 2 selects the unsigned variants (BU/HU)
        load_data = size_q[1:0] == 2'd0 ? {{24{~size_q[2] & byte_lane[7]}}, byte_lane} :
                    size_q[1:0] == 2'd1 ? {{16{~size_q[2] & half_lane[15]}}, half_lane} : mem_rd_i;
        timeout = (TIMEOUT != 32'd0) && (timer == TIMEOUT - 32'd1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            size_q       <= 3'd0;
            lane_q       <= 2'd0;
            timer        <= 32'd0;
            core_rd_o    <= 32'd0;
            fault_o      <= 1'b0;
            fault_code_o <= 2'd0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_be_o     <= 4'd0;
            mem_addr_o   <= 32'd0;
            mem_wd_o     <= 32'd0;
        end else begin
            case (state)
                IDLE: if (core_req_i) begin
                    size_q       <= core_size_i;
                    lane_q       <= core_addr_i[1:0];
                    timer        <= 32'd0;
                    core_rd_o    <= 32'd0;
                    fault_o      <= illegal | misaligned;
                    fault_code_o <= illegal ? 2'd2 : misaligned ? 2'd1 : 2'd0;
                    if (illegal || misaligned) begin
                        state <= DONE;
                    end else begin
                        state      <= REQ;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= core_we_i;
                        mem_be_o   <= be;
                        mem_addr_o <= {core_addr_i[31:2], 2'b00};
                        mem_wd_o   <= wd;
                    end
                end
                REQ: if (mem_ack_i || timeout) begin
                    // an ack arriving on the timeout cycle still completes normally
                    core_rd_o    <= (mem_ack_i && !mem_we_o) ? load_data : 32'd0;
                    fault_o      <= !mem_ack_i;
                    fault_code_o <= mem_ack_i ? 2'd0 : 2'd3;
                    state        <= DONE;
                    mem_req_o    <= 1'b0;
                    mem_we_o     <= 1'b0;
                    mem_be_o     <= 4'd0;
                    mem_addr_o   <= 32'd0;
                    mem_wd_o     <= 32'd0;
                end else begin
                    timer <= timer + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
